// File: rtl/pipeline_cpu_top.sv
// pipeline_cpu_top: board top of a 5-stage (IF/ID/EX/MEM/WB) 32-bit MIPS-subset
// CPU with program ROM, data RAM, push-button single-step and debug exports.
// Optional macro LCD_EN: instantiate the 4-bit LCD driver on LCDRS/LCDE/LCDDAT.
module pipeline_cpu_top #(
  parameter int IMEM_WORDS = 32,
  parameter int DMEM_WORDS = 32
) (
  input  logic        CCLK,
  input  logic        BTN3,
  input  logic        BTN1,
  input  logic        BTN2,
  input  logic [3:0]  SW,
  output logic        LCDRS,
  output logic        LCDRW,
  output logic        LCDE,
  output logic [3:0]  LCDDAT,
  output logic [7:0]  LED,
  output logic [31:0] disp_num,
  output logic [31:0] PC,
  output logic [31:0] AAdat,
  output logic [31:0] BBdat,
  output logic [31:0] Result,
  output logic [2:0]  ALUoper,
  output logic        JUMP_ID_EX,
  output logic        BEQ_EX_MEM,
  output logic        BNE_EX_MEM,
  output logic        ZERO_EX_MEM
);
  localparam int IAW = (IMEM_WORDS > 1) ? $clog2(IMEM_WORDS) : 1;
  localparam int DAW = (DMEM_WORDS > 1) ? $clog2(DMEM_WORDS) : 1;

  localparam logic [5:0] OP_R = 6'h00, OP_J = 6'h02, OP_BEQ = 6'h04, OP_BNE = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08, OP_ANDI = 6'h0C, OP_ORI = 6'h0D;
  localparam logic [5:0] OP_LW = 6'h23, OP_SW = 6'h2B;
  localparam logic [5:0] F_SLL = 6'h00, F_SRL = 6'h02, F_SRA = 6'h03, F_ADD = 6'h20;
  localparam logic [5:0] F_SUB = 6'h22, F_AND = 6'h24, F_OR = 6'h25, F_SLT = 6'h2A;

  typedef enum logic [2:0] {
    ALU_AND = 3'b000, ALU_OR  = 3'b001, ALU_ADD = 3'b010, ALU_SLL = 3'b011,
    ALU_SRL = 3'b100, ALU_SRA = 3'b101, ALU_SUB = 3'b110, ALU_SLT = 3'b111
  } alu_op_e;

  typedef struct packed { logic [31:0] pc4; logic [31:0] instr; } if_id_t;
  typedef struct packed {
    logic [31:0] pc4, a, b, imm;
    logic [25:0] target;
    logic [4:0]  dest;
    alu_op_e     alu_op;
    logic        alu_imm, reg_write, mem_read, mem_write, beq, bne, jump;
  } id_ex_t;
  typedef struct packed {
    logic [31:0] br_target, result, store;
    logic [4:0]  dest;
    logic        zero, reg_write, mem_read, mem_write, beq, bne;
  } ex_mem_t;
  typedef struct packed {
    logic [31:0] result, load;
    logic [4:0]  dest;
    logic        reg_write, mem_to_reg;
  } mem_wb_t;

  logic clk, rst;
  assign clk = CCLK;
  assign rst = BTN3;

  logic        btn2_s1_q, btn2_s1_d, btn2_s2_q, btn2_s2_d, btn2_prev_q, btn2_prev_d;
  logic [31:0] pc_q, pc_d;
  if_id_t      if_id_q, if_id_d;
  id_ex_t      id_ex_q, id_ex_d, dec;
  ex_mem_t     ex_mem_q, ex_mem_d, ex_next;
  mem_wb_t     mem_wb_q, mem_wb_d, mem_next;
  logic [31:0] rf_q [32];
  logic [31:0] rf_d [32];
  logic [31:0] dmem_q [DMEM_WORDS];
  logic [31:0] dmem_d [DMEM_WORDS];

  logic        adv, stall, br_taken, wb_we, uses_rs, uses_rt, haz_e, haz_m;
  logic [31:0] instr_if, pc_seq, rf_a, rf_b, wb_data, alu_y;
  logic [4:0]  rs, rt, rd;

  // Program ROM; unlisted words are NOPs.
  function automatic logic [31:0] rom_word(input logic [IAW-1:0] idx);
    case (32'(idx))
      0:  return 32'h2010_0005;  // addi s0,zero,5
      1:  return 32'h3011_0000;  // andi s1,zero,0
      2:  return 32'h3631_0003;  // ori  s1,s1,3
      3:  return 32'h0211_9020;  // add  s2,s0,s1
      4:  return 32'h0211_9822;  // sub  s3,s0,s1
      5:  return 32'h0211_A024;  // and  s4,s0,s1
      6:  return 32'h0211_A825;  // or   s5,s0,s1
      7:  return 32'h0010_8082;  // srl  s0,s0,2
      8:  return 32'h0010_87C0;  // sll  s0,s0,31
      9:  return 32'h0010_87C3;  // sra  s0,s0,31
      10: return 32'hAC12_0000;  // sw   s2,0(zero)
      11: return 32'h8C13_0000;  // lw   s3,0(zero)
      12: return 32'h2252_FFFF;  // addi s2,s2,-1
      13: return 32'h1253_0002;  // jump: beq s2,s3,2
      14: return 32'h2252_0001;  // addi s2,s2,1
      15: return 32'h0800_000D;  // j jump
      16: return 32'h1653_0002;  // bne  s2,s3,2
      17: return 32'h2272_FFFF;  // addi s2,s3,-1
      18: return 32'h2252_0001;  // addi s2,s2,1
      default: return 32'h0000_0000;
    endcase
  endfunction

  // Step control: one advance per synchronised rising edge of BTN2 in step mode.
  always_comb begin
    // NOTE: combinational blocks use blocking '='; only clocked blocks use '<='.
    btn2_s1_d   = BTN2;
    btn2_s2_d   = btn2_s1_q;
    btn2_prev_d = btn2_s2_q;
  end
  assign adv = BTN1 ? (btn2_s2_q & ~btn2_prev_q) : 1'b1;

  // IF: sequential PC wraps modulo the ROM depth.
  assign instr_if = rom_word(pc_q[IAW+1:2]);
  assign pc_seq   = (32'(pc_q[IAW+1:2]) == IMEM_WORDS - 1) ? 32'd0 : pc_q + 32'd4;

  // ID: register read sees the WB write of the same cycle (write-before-read).
  assign rs      = if_id_q.instr[25:21];
  assign rt      = if_id_q.instr[20:16];
  assign rd      = if_id_q.instr[15:11];
  assign wb_we   = mem_wb_q.reg_write && (mem_wb_q.dest != 5'd0);
  assign wb_data = mem_wb_q.mem_to_reg ? mem_wb_q.load : mem_wb_q.result;
  assign rf_a    = (rs == 5'd0) ? 32'd0 : (wb_we && mem_wb_q.dest == rs) ? wb_data : rf_q[rs];
  assign rf_b    = (rt == 5'd0) ? 32'd0 : (wb_we && mem_wb_q.dest == rt) ? wb_data : rf_q[rt];

  // ID: decode into the ID/EX record; shifts take rt as operand A and shamt as B.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    dec        = '0;
    uses_rs    = 1'b0;
    uses_rt    = 1'b0;
    dec.pc4    = if_id_q.pc4;
    dec.a      = rf_a;
    dec.b      = rf_b;
    dec.target = if_id_q.instr[25:0];
    dec.imm    = {{16{if_id_q.instr[15]}}, if_id_q.instr[15:0]};
    case (if_id_q.instr[31:26])
      OP_R: begin
        dec.dest = rd; dec.reg_write = 1'b1; uses_rs = 1'b1; uses_rt = 1'b1;
        case (if_id_q.instr[5:0])
          F_ADD:   dec.alu_op = ALU_ADD;
          F_SUB:   dec.alu_op = ALU_SUB;
          F_AND:   dec.alu_op = ALU_AND;
          F_OR:    dec.alu_op = ALU_OR;
          F_SLT:   dec.alu_op = ALU_SLT;
          F_SLL, F_SRL, F_SRA: begin
            dec.alu_op  = (if_id_q.instr[5:0] == F_SLL) ? ALU_SLL :
                          (if_id_q.instr[5:0] == F_SRL) ? ALU_SRL : ALU_SRA;
            dec.a       = rf_b;
            dec.imm     = {27'd0, if_id_q.instr[10:6]};
            dec.alu_imm = 1'b1;
          end
          default: dec.reg_write = 1'b0;
        endcase
      end
      OP_ADDI: begin dec.alu_op = ALU_ADD; dec.alu_imm = 1'b1; dec.dest = rt; dec.reg_write = 1'b1; uses_rs = 1'b1; end
      OP_ANDI, OP_ORI: begin
        dec.alu_op  = (if_id_q.instr[31:26] == OP_ANDI) ? ALU_AND : ALU_OR;
        dec.imm     = {16'd0, if_id_q.instr[15:0]};
        dec.alu_imm = 1'b1; dec.dest = rt; dec.reg_write = 1'b1; uses_rs = 1'b1;
      end
      OP_LW: begin dec.alu_op = ALU_ADD; dec.alu_imm = 1'b1; dec.dest = rt; dec.reg_write = 1'b1; dec.mem_read = 1'b1; uses_rs = 1'b1; end
      OP_SW: begin dec.alu_op = ALU_ADD; dec.alu_imm = 1'b1; dec.mem_write = 1'b1; uses_rs = 1'b1; uses_rt = 1'b1; end
      OP_BEQ, OP_BNE: begin
        dec.alu_op = ALU_SUB; uses_rs = 1'b1; uses_rt = 1'b1;
        dec.beq    = (if_id_q.instr[31:26] == OP_BEQ);
        dec.bne    = (if_id_q.instr[31:26] == OP_BNE);
      end
      OP_J:    dec.jump = 1'b1;
      default: ;
    endcase
  end

  // Without forwarding, any in-flight writer of an ID source in EX or MEM stalls ID.
  assign haz_e = id_ex_q.reg_write && (id_ex_q.dest != 5'd0) &&
                 ((uses_rs && rs == id_ex_q.dest) || (uses_rt && rt == id_ex_q.dest));
  assign haz_m = ex_mem_q.reg_write && (ex_mem_q.dest != 5'd0) &&
                 ((uses_rs && rs == ex_mem_q.dest) || (uses_rt && rt == ex_mem_q.dest));
  assign stall = haz_e | haz_m;

  // EX: ALU on operand A and the immediate-muxed operand B.
  assign BBdat = id_ex_q.alu_imm ? id_ex_q.imm : id_ex_q.b;
  always_comb begin
    case (id_ex_q.alu_op)
      ALU_AND: alu_y = id_ex_q.a & BBdat;
      ALU_OR:  alu_y = id_ex_q.a | BBdat;
      ALU_ADD: alu_y = id_ex_q.a + BBdat;
      ALU_SUB: alu_y = id_ex_q.a - BBdat;
      ALU_SLT: alu_y = {31'd0, $signed(id_ex_q.a) < $signed(BBdat)};
      ALU_SLL: alu_y = id_ex_q.a << BBdat[4:0];
      ALU_SRL: alu_y = id_ex_q.a >> BBdat[4:0];
      ALU_SRA: alu_y = $signed(id_ex_q.a) >>> BBdat[4:0];
      default: alu_y = '0;
    endcase
  end

  // EX/MEM and MEM/WB candidate records; the branch resolves from EX/MEM.
  always_comb begin
    ex_next           = '0;
    ex_next.br_target = id_ex_q.pc4 + {id_ex_q.imm[29:0], 2'b00};
    ex_next.result    = alu_y;
    ex_next.store     = id_ex_q.b;
    ex_next.zero      = (alu_y == 32'd0);
    ex_next.dest      = id_ex_q.dest;
    ex_next.reg_write = id_ex_q.reg_write;
    ex_next.mem_read  = id_ex_q.mem_read;
    ex_next.mem_write = id_ex_q.mem_write;
    ex_next.beq       = id_ex_q.beq;
    ex_next.bne       = id_ex_q.bne;
    mem_next            = '0;
    mem_next.result     = ex_mem_q.result;
    mem_next.load       = dmem_q[ex_mem_q.result[DAW+1:2]];
    mem_next.dest       = ex_mem_q.dest;
    mem_next.reg_write  = ex_mem_q.reg_write;
    mem_next.mem_to_reg = ex_mem_q.mem_read;
  end
  assign br_taken = (ex_mem_q.beq & ex_mem_q.zero) | (ex_mem_q.bne & ~ex_mem_q.zero);

  // Pipeline advance: branch beats jump beats stall beats normal flow.
  always_comb begin
    pc_d = pc_q; if_id_d = if_id_q; id_ex_d = id_ex_q; ex_mem_d = ex_mem_q; mem_wb_d = mem_wb_q;
    rf_d = rf_q; dmem_d = dmem_q;
    if (adv) begin
      mem_wb_d = mem_next;
      ex_mem_d = ex_next;
      if (wb_we)              rf_d[mem_wb_q.dest] = wb_data;
      if (ex_mem_q.mem_write) dmem_d[ex_mem_q.result[DAW+1:2]] = ex_mem_q.store;
      if (br_taken) begin
        pc_d = ex_mem_q.br_target; if_id_d = '0; id_ex_d = '0; ex_mem_d = '0;
      end else if (id_ex_q.jump) begin
        pc_d = {id_ex_q.pc4[31:28], id_ex_q.target, 2'b00}; if_id_d = '0; id_ex_d = '0;
      end else if (stall) begin
        id_ex_d = '0;
      end else begin
        pc_d = pc_seq; if_id_d = '{pc4: pc_q + 32'd4, instr: instr_if}; id_ex_d = dec;
      end
    end
  end

  // State registers, cleared asynchronously by BTN3.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn2_s1_q <= 1'b0; btn2_s2_q <= 1'b0; btn2_prev_q <= 1'b0;
      pc_q <= '0; if_id_q <= '0; id_ex_q <= '0; ex_mem_q <= '0; mem_wb_q <= '0;
      // NOTE: register file and data RAM are flop arrays so they can be cleared on reset.
      rf_q   <= '{default: '0};
      dmem_q <= '{default: '0};
    end else begin
      btn2_s1_q <= btn2_s1_d; btn2_s2_q <= btn2_s2_d; btn2_prev_q <= btn2_prev_d;
      pc_q <= pc_d; if_id_q <= if_id_d; id_ex_q <= id_ex_d; ex_mem_q <= ex_mem_d; mem_wb_q <= mem_wb_d;
      rf_q   <= rf_d;
      dmem_q <= dmem_d;
    end
  end

  assign PC          = pc_q;
  assign LED         = pc_q[9:2];
  assign disp_num    = rf_q[{1'b1, SW}];
  assign AAdat       = id_ex_q.a;
  assign Result      = alu_y;
  assign ALUoper     = id_ex_q.alu_op;
  assign JUMP_ID_EX  = id_ex_q.jump;
  assign BEQ_EX_MEM  = ex_mem_q.beq;
  assign BNE_EX_MEM  = ex_mem_q.bne;
  assign ZERO_EX_MEM = ex_mem_q.zero;
  assign LCDRW       = 1'b0;

`ifdef LCD_EN
  lcd_driver u_lcd (
    .clk     (clk),
    .rst     (rst),
    .data    (disp_num),
    .lcd_rs  (LCDRS),
    .lcd_e   (LCDE),
    .lcd_dat (LCDDAT)
  );
`else
  assign LCDRS  = 1'b0;
  assign LCDE   = 1'b0;
  assign LCDDAT = 4'd0;
`endif
endmodule

// File: tb/tb_pipeline_cpu_top.sv
// tb_pipeline_cpu_top: reset, single-step and full-program checks of pipeline_cpu_top.
module tb_pipeline_cpu_top;
  logic        CCLK = 1'b0;
  logic        BTN3, BTN1, BTN2;
  logic [3:0]  SW;
  logic        LCDRS, LCDRW, LCDE;
  logic [3:0]  LCDDAT;
  logic [7:0]  LED;
  logic [31:0] disp_num, PC, AAdat, BBdat, Result;
  logic [2:0]  ALUoper;
  logic        JUMP_ID_EX, BEQ_EX_MEM, BNE_EX_MEM, ZERO_EX_MEM;

  pipeline_cpu_top dut (
    .CCLK(CCLK), .BTN3(BTN3), .BTN1(BTN1), .BTN2(BTN2), .SW(SW),
    .LCDRS(LCDRS), .LCDRW(LCDRW), .LCDE(LCDE), .LCDDAT(LCDDAT), .LED(LED),
    .disp_num(disp_num), .PC(PC), .AAdat(AAdat), .BBdat(BBdat), .Result(Result),
    .ALUoper(ALUoper), .JUMP_ID_EX(JUMP_ID_EX), .BEQ_EX_MEM(BEQ_EX_MEM),
    .BNE_EX_MEM(BNE_EX_MEM), .ZERO_EX_MEM(ZERO_EX_MEM)
  );

  always #5 CCLK = ~CCLK;

  typedef struct { int step; logic [3:0] sw; logic [31:0] disp; logic [31:0] pc; } vec_t;
  typedef struct { string name; logic [31:0] disp; logic [31:0] pc; } exp_t;

  vec_t vecs [10];
  exp_t sb [$];
  int   checks = 0;
  int   failures = 0;
  int   adv_count = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Free-run until the pipeline has made 'target' advances, then freeze in step mode.
  task automatic run_to(input int target);
    if (target > adv_count) begin
      @(negedge CCLK);
      BTN1 = 1'b0;
      repeat (target - adv_count) @(negedge CCLK);
      BTN1 = 1'b1;
      adv_count = target;
    end
    #1;
  endtask

  initial begin
    exp_t e;
    // Register values after a given number of advances (stalls included).
    vecs[0] = '{15, 4'd0, 32'd5,          32'd36};
    vecs[1] = '{15, 4'd1, 32'd3,          32'd36};
    vecs[2] = '{15, 4'd2, 32'd8,          32'd36};
    vecs[3] = '{15, 4'd3, 32'd2,          32'd36};
    vecs[4] = '{15, 4'd4, 32'd1,          32'd36};
    vecs[5] = '{15, 4'd5, 32'd7,          32'd36};
    vecs[6] = '{22, 4'd0, 32'hFFFF_FFFF,  32'd56};
    vecs[7] = '{25, 4'd3, 32'd8,          32'd60};
    vecs[8] = '{25, 4'd2, 32'd7,          32'd60};
    vecs[9] = '{41, 4'd2, 32'd8,          32'd92};

    BTN3 = 1'b1; BTN1 = 1'b1; BTN2 = 1'b0; SW = 4'd0;
    repeat (3) @(negedge CCLK);
    BTN3 = 1'b0;
    #1;
    check("reset_pc", PC, 32'd0);
    check("reset_led", {24'd0, LED}, 32'd0);
    check("reset_disp", disp_num, 32'd0);
    check("reset_flags", {28'd0, JUMP_ID_EX, BEQ_EX_MEM, BNE_EX_MEM, ZERO_EX_MEM}, 32'd0);
    check("reset_alu", {29'd0, ALUoper} | AAdat | BBdat | Result, 32'd0);
    check("lcd_idle", {25'd0, LCDRS, LCDRW, LCDE, LCDDAT}, 32'd0);

    // Single step: one press advances once, however long it is held.
    @(negedge CCLK); BTN2 = 1'b1;
    @(negedge CCLK); #1;
    check("step_sync_latency", PC, 32'd0);
    repeat (49) @(negedge CCLK);
    #1;
    check("step_one_press", PC, 32'd4);
    BTN2 = 1'b0;
    repeat (5) @(negedge CCLK);
    #1;
    check("step_release", PC, 32'd4);
    adv_count = 1;

    // Table-driven register checks through the scoreboard.
    for (int i = 0; i < 10; i++) begin
      run_to(vecs[i].step);
      SW = vecs[i].sw;
      sb.push_back('{$sformatf("reg_s%0d_at_%0d", vecs[i].sw, vecs[i].step), vecs[i].disp, vecs[i].pc});
      #1;
      e = sb.pop_front();
      check({e.name, "_disp"}, disp_num, e.disp);
      check({e.name, "_pc"}, PC, e.pc);
      if (i == 5) begin
        run_to(16);
        check("sll_aluoper", {29'd0, ALUoper}, 32'd3);
        check("sll_result", Result, 32'h8000_0000);
        check("sll_a", AAdat, 32'd1);
        check("sll_b_shamt", BBdat, 32'd31);
      end
      if (i == 8) begin
        run_to(26);
        check("beq1_flag", {31'd0, BEQ_EX_MEM}, 32'd1);
        check("beq1_zero", {31'd0, ZERO_EX_MEM}, 32'd0);
        run_to(27);
        check("jump_flag", {31'd0, JUMP_ID_EX}, 32'd1);
        check("jump_pc_before", PC, 32'd68);
        run_to(28);
        check("jump_target_pc", PC, 32'd52);
        check("jump_flushed", {31'd0, JUMP_ID_EX}, 32'd0);
        run_to(31);
        check("beq2_flag", {31'd0, BEQ_EX_MEM}, 32'd1);
        check("beq2_zero", {31'd0, ZERO_EX_MEM}, 32'd1);
        run_to(32);
        check("beq2_taken_pc", PC, 32'd64);
        run_to(35);
        check("bne_flag", {31'd0, BNE_EX_MEM}, 32'd1);
        check("bne_zero", {31'd0, ZERO_EX_MEM}, 32'd1);
        run_to(38);
        check("bne_not_taken_pc", PC, 32'd80);
      end
    end

    // PC walks the NOP tail and wraps after word 31.
    run_to(49);
    check("pc_last_word", PC, 32'd124);
    check("led_last_word", {24'd0, LED}, 32'h1F);
    run_to(50);
    check("pc_wrap", PC, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pipeline_cpu_top.md
Name: pipeline_cpu_top

Overview:
- Board-level top of a 5-stage (IF/ID/EX/MEM/WB) 32-bit MIPS-subset pipelined CPU.
- Holds the program in an internal ROM and has a small internal data RAM.
- The pipeline can be single-stepped from a push button.
- Selected register contents, PC and ALU/branch pipeline signals are exported for LCD display and debug.

Parameters:
- IMEM_WORDS, 32, instruction ROM depth in words; PC wraps modulo depth.
- DMEM_WORDS, 32, data RAM depth in words.

Ports:
- CCLK  in  1  system clock; all state updates on rising edge.
- BTN3  in  1  reset, asynchronous, active-high.
- BTN1  in  1  step mode: 1 = advance only on BTN2 press, 0 = free-run every CCLK.
- BTN2  in  1  step button, raw level, synchronised internally.
- SW  in  4  display select: disp_num = register 16+SW.
- LCDRS  out  1  LCD register select.
- LCDRW  out  1  LCD read/write, always 0.
- LCDE  out  1  LCD enable strobe.
- LCDDAT  out  4  LCD 4-bit data.
- LED  out  8  PC[9:2].
- disp_num  out  32  register-file word selected by SW.
- PC  out  32  current IF program counter.
- AAdat  out  32  ALU operand A in EX.
- BBdat  out  32  ALU operand B in EX (after immediate mux).
- Result  out  32  ALU result in EX.
- ALUoper  out  3  ALU op code in EX.
- JUMP_ID_EX  out  1  jump flag in ID/EX register.
- BEQ_EX_MEM  out  1  beq flag in EX/MEM register.
- BNE_EX_MEM  out  1  bne flag in EX/MEM register.
- ZERO_EX_MEM  out  1  ALU zero flag in EX/MEM register.

Behaviour:
- Reset (async, BTN3=1):
  - PC=0.
  - All pipeline registers cleared to NOP (all flags 0).
  - Register file and data RAM cleared to 0.
  - All exported outputs 0.
- Advance enable:
  - BTN1=0: enable every CCLK.
  - BTN1=1: enable for exactly one CCLK on each rising edge of BTN2, detected after a 2-flop synchroniser. A held button gives one advance.
- ISA: add, sub, and, or, slt, sll, srl, sra (shamt), addi, andi, ori, lw, sw, beq, bne, j.
  - subi is assembled as addi with a negative immediate.
  - addi/lw/sw/beq/bne sign-extend the immediate; andi/ori zero-extend it.
- ALUoper codes: 000 and, 001 or, 010 add, 110 sub, 111 slt, 011 sll, 100 srl, 101 sra. Zero flag = (Result==0).
- Register file:
  - $0 is always 0.
  - Written in WB on the first half of the cycle, i.e. write-before-read, so the ID read sees same-cycle WB data.
- Hazards: no forwarding. ID stalls (PC and IF/ID hold, bubble into ID/EX) while an ID source register equals a non-zero destination in ID/EX or EX/MEM.
- j: resolved when in ID/EX. PC <= {PC[31:28], target, 00}. IF/ID and ID/EX are flushed.
- beq/bne: resolved in EX/MEM.
  - Taken when (BEQ & ZERO) | (BNE & ~ZERO).
  - PC <= branch PC+4 + (simm<<2).
  - IF/ID, ID/EX and EX/MEM-bound instructions are flushed.
  - Branch has priority over a simultaneous jump.
- Memory: word-addressed by address[6:2]; lw data available to WB; sw writes in MEM.
- ROM content, word addresses 0..18:
  - 0: addi s0,zero,5
  - 1: andi s1,zero,0
  - 2: ori s1,s1,3
  - 3: add s2,s0,s1
  - 4: sub s3,s0,s1
  - 5: and s4,s0,s1
  - 6: or s5,s0,s1
  - 7: srl s0,s0,2
  - 8: sll s0,s0,31
  - 9: sra s0,s0,31
  - 10: sw s2,0(zero)
  - 11: lw s3,0(zero)
  - 12: addi s2,s2,-1
  - 13 (jump): beq s2,s3,2
  - 14: addi s2,s2,1
  - 15: j jump
  - 16: bne s2,s3,2
  - 17: addi s2,s3,-1
  - 18: addi s2,s2,1
  - All remaining words are 0 (NOP).
- LCD: shows disp_num as 8 hex digits, refreshed continuously by the codebase's standard 4-bit LCD driver instance.

Optional Feature:
- Macro LCD_EN.
- Defined: LCD driver instantiated and driving LCDRS/LCDE/LCDDAT.
- Undefined: LCDRS=0, LCDRW=0, LCDE=0, LCDDAT=0, and no driver logic is synthesised. Exported values are otherwise unaffected.

Test Plan:
- Assert BTN3, then release: PC=0, disp_num=0, all flags 0, LED=0.
- BTN1=1, one BTN2 press: PC=4. Holding BTN2 high for 50 cycles gives no further advance.
- BTN1=0, run to completion of addr 6:
  - SW=0 gives 5, SW=1 gives 3, SW=2 gives 8, SW=3 gives 2, SW=4 gives 1, SW=5 gives 7.
  - The ori s1 hazard is covered by the stall.
- Run through addr 9: SW=0 gives 0xFFFFFFFF; in EX of the sll, ALUoper=011 and Result=0x80000000.
- Run through addr 12: s3=8 (load of stored s2), s2=7. The first beq is not taken (BEQ_EX_MEM=1, ZERO_EX_MEM=0).
- After the loop:
  - j sets JUMP_ID_EX=1, and the second beq is taken.
  - bne is not taken (BNE_EX_MEM=1, ZERO_EX_MEM=1).
  - Final s2 (SW=2) = 8.
  - PC then advances through NOPs and wraps to 0 after word 31.
